// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register carrying PC, payload and control with flush and stall counter.
// Define PIPE_SKID_EN for a 2-entry skid buffer with a registered in_ready.
module pipe_stage_reg #(
    parameter int PC_W   = 16,
    parameter int DATA_W = 64,
    parameter int CTRL_W = 9,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  stall_count
);

    logic              accept;
    logic              deliver;
    logic [PC_W-1:0]   pc_reg;
    logic [DATA_W-1:0] data_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [CNT_W-1:0]  stall_reg;

    assign accept  = in_valid && in_ready;
    assign deliver = out_valid && out_ready;

`ifdef PIPE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic              skid_valid_reg;
    logic [PC_W-1:0]   skid_pc_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic [CTRL_W-1:0] skid_ctrl_reg;
    logic              load_main;
    logic              load_skid;
    logic              skid_to_main;

    always_comb begin
        state_next   = state_reg;
        load_main    = 1'b0;
        load_skid    = 1'b0;
        skid_to_main = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        state_next = ONE;
                        load_main  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_next = TWO;
                        load_skid  = 1'b1;
                    end else if (deliver) begin
                        state_next = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a delivery can move us
                    if (deliver) begin
                        state_next   = ONE;
                        skid_to_main = 1'b1;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= EMPTY;
            skid_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            skid_valid_reg <= (state_next == TWO);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_reg        <= '0;
            data_reg      <= '0;
            ctrl_reg      <= '0;
            skid_pc_reg   <= '0;
            skid_data_reg <= '0;
            skid_ctrl_reg <= '0;
        end else begin
            if (load_main) begin
                pc_reg   <= in_pc;
                data_reg <= in_data;
                ctrl_reg <= in_ctrl;
            end else if (skid_to_main) begin
                pc_reg   <= skid_pc_reg;
                data_reg <= skid_data_reg;
                ctrl_reg <= skid_ctrl_reg;
            end
            if (load_skid) begin
                skid_pc_reg   <= in_pc;
                skid_data_reg <= in_data;
                skid_ctrl_reg <= in_ctrl;
            end
        end
    end

    assign in_ready  = !skid_valid_reg;
    assign out_valid = (state_reg != EMPTY);
`else
    logic valid_reg;

    assign in_ready  = flush || !valid_reg || out_ready;
    assign out_valid = valid_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            pc_reg    <= '0;
            data_reg  <= '0;
            ctrl_reg  <= '0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            pc_reg    <= in_pc;
            data_reg  <= in_data;
            ctrl_reg  <= in_ctrl;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_reg != {CNT_W{1'b1}})) begin
            stall_reg <= stall_reg + CNT_W'(1);
        end
    end

    // An empty stage presents a NOP: every control bit is gated by out_valid
    genvar gi;
    generate
        for (gi = 0; gi < CTRL_W; gi++) begin : g_ctrl_mask
            assign out_ctrl[gi] = ctrl_reg[gi] & out_valid;
        end
    endgenerate

    assign out_pc      = pc_reg;
    assign out_data    = data_reg;
    assign stall_count = stall_reg;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed scoreboard bench for pipe_stage_reg; a second CNT_W=4 instance covers counter saturation.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_pc;
    logic [63:0] in_data;
    logic [8:0]  in_ctrl;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_pc;
    logic [63:0] out_data;
    logic [8:0]  out_ctrl;
    logic [15:0] stall_count;

    logic        s_in_valid;
    logic        s_in_ready;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [15:0] s_out_pc;
    logic [63:0] s_out_data;
    logic [8:0]  s_out_ctrl;
    logic [3:0]  s_stall_count;

    typedef struct {
        logic [15:0] pc;
        logic [63:0] data;
        logic [8:0]  ctrl;
    } beat_t;

    beat_t q[$];
    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_ctrl(in_ctrl),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_ctrl(out_ctrl),
        .stall_count(stall_count)
    );

    pipe_stage_reg #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_in_valid), .in_ready(s_in_ready),
        .in_pc(16'h0050), .in_data(64'h5), .in_ctrl(9'h001),
        .flush(1'b0),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .out_pc(s_out_pc), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
        .stall_count(s_stall_count)
    );

    function automatic logic [63:0] mk_data(input logic [15:0] pc);
        return {pc, ~pc, pc ^ 16'h5A5A, 16'hC0DE};
    endfunction

    function automatic logic [8:0] mk_ctrl(input logic [15:0] pc);
        return 9'h100 | pc[8:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [15:0] pc);
        in_valid = 1'b1;
        in_pc    = pc;
        in_data  = mk_data(pc);
        in_ctrl  = mk_ctrl(pc);
    endtask

    // One clock: handshakes are observed at the falling edge, then time moves to just after the rising edge
    task automatic cycle();
        beat_t b;
        beat_t e;
        @(negedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_beat_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("deliver_pc", 64'(out_pc), 64'(e.pc));
                    check("deliver_data", out_data, e.data);
                    check("deliver_ctrl", 64'(out_ctrl), 64'(e.ctrl));
                    $display("deliver pc=%04h data=%016h ctrl=%03h", out_pc, out_data, out_ctrl);
                end
            end
            if (in_valid && in_ready) begin
                b.pc   = in_pc;
                b.data = in_data;
                b.ctrl = in_ctrl;
                q.push_back(b);
                $display("accept  pc=%04h data=%016h ctrl=%03h", in_pc, in_data, in_ctrl);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] next_pc;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_pc       = '0;
        in_data     = '0;
        in_ctrl     = '0;
        flush       = 1'b0;
        out_ready   = 1'b0;
        s_in_valid  = 1'b0;
        s_out_ready = 1'b1;

        // Reset state
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_pc", 64'(out_pc), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_ctrl", 64'(out_ctrl), 64'd0);
        check("rst_stall", 64'(stall_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Saturation on the 4-bit counter instance
        s_in_valid  = 1'b1;
        s_out_ready = 1'b0;
        cycle();
        s_in_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (i == 14) check("sat_at_14", 64'(s_stall_count), 64'd14);
            cycle();
        end
        check("sat_stops_15", 64'(s_stall_count), 64'd15);
        check("sat_valid_held", 64'(s_out_valid), 64'd1);
        s_out_ready = 1'b1;
        cycle();

        // Streaming: 8 beats back to back with out_ready high
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            offer(16'(2 * k));
            cycle();
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_pc", 64'(out_pc), 64'(2 * k));
        end
        in_valid = 1'b0;
        cycle();
        check("stream_drained", 64'(out_valid), 64'd0);
        check("stream_sb_empty", 64'(q.size()), 64'd0);
        check("stream_no_stall", 64'(stall_count), 64'd0);

        // Back-pressure: load one beat, then 5 stalled cycles with input offered
        out_ready = 1'b0;
        next_pc   = 16'h0020;
        for (int i = 0; i < 6; i++) begin
            offer(next_pc);
            @(negedge clk);
            if (in_ready) next_pc = next_pc + 16'd2;
            #0;
            cycle_tail();
        end
        check("bp_stall5", 64'(stall_count), 64'd5);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        check("bp_head_pc", 64'(out_pc), 64'h20);
`ifdef PIPE_SKID_EN
        check("bp_held_beats", 64'(q.size()), 64'd2);
`else
        check("bp_held_beats", 64'(q.size()), 64'd1);
`endif
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        check("bp_released", 64'(out_valid), 64'd0);
        check("bp_sb_empty", 64'(q.size()), 64'd0);
        check("bp_stall_kept", 64'(stall_count), 64'd5);

        // Flush: beat 0x10 held, 0x12 offered with flush
        out_ready = 1'b0;
        offer(16'h0010);
        cycle();
        check("fl_held", 64'(out_pc), 64'h10);
        offer(16'h0012);
        flush = 1'b1;
        #1;
        check("fl_in_ready", 64'(in_ready), 64'd1);
        cycle();
        flush = 1'b0;
        check("fl_out_valid", 64'(out_valid), 64'd0);
        check("fl_out_ctrl", 64'(out_ctrl), 64'd0);
        check("fl_pc_kept", 64'(out_pc), 64'h10);
        check("fl_stall_same", 64'(stall_count), 64'd5);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("fl_no_ghost", 64'(out_valid), 64'd0);
        end

        // Bubble: all-ones control delivered, then the stage shows a NOP
        offer(16'h0030);
        in_ctrl = 9'h1FF;
        cycle();
        in_valid = 1'b0;
        check("bub_ctrl_loaded", 64'(out_ctrl), 64'h1FF);
        cycle();
        check("bub_out_valid", 64'(out_valid), 64'd0);
        check("bub_out_ctrl", 64'(out_ctrl), 64'h000);
        check("bub_pc_kept", 64'(out_pc), 64'h30);

        // Reset asserted mid-transfer with a beat held and stalls counted
        out_ready = 1'b0;
        offer(16'h0034);
        cycle();
        cycle();
        check("mr_pre_valid", 64'(out_valid), 64'd1);
        check("mr_pre_stall", 64'(stall_count), 64'd6);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("mr_out_valid", 64'(out_valid), 64'd0);
        check("mr_out_ctrl", 64'(out_ctrl), 64'd0);
        check("mr_stall", 64'(stall_count), 64'd0);
        check("mr_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        offer(16'h0040);
        cycle();
        in_valid = 1'b0;
        check("mr_reload_pc", 64'(out_pc), 64'h40);
        cycle();
        check("mr_final_empty", 64'(q.size()), 64'd0);
        check("mr_final_valid", 64'(out_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Second half of cycle() for steps that already sat on the falling edge
    task automatic cycle_tail();
        beat_t b;
        beat_t e;
        if (!flush) begin
            if (out_valid && out_ready) begin
                check("sb_beat_expected", 64'(q.size() > 0), 64'd1);
                if (q.size() > 0) begin
                    e = q.pop_front();
                    check("deliver_pc", 64'(out_pc), 64'(e.pc));
                end
            end
            if (in_valid && in_ready) begin
                b.pc   = in_pc;
                b.data = in_data;
                b.ctrl = in_ctrl;
                q.push_back(b);
                $display("accept  pc=%04h data=%016h ctrl=%03h", in_pc, in_data, in_ctrl);
            end
        end else begin
            q.delete();
        end
        @(posedge clk);
        #1;
    endtask

endmodule
